// File: rtl/hsv_track_pkg.sv
// Shared types and widths for the HSV colour tracker: FSM states, the
// threshold bundle and the bit-width helper used for geometry-derived ports.
package hsv_track_pkg;

  localparam int DEF_IMG_W   = 640;
  localparam int DEF_IMG_H   = 480;
  localparam int DEF_MIN_PIX = 64;

  localparam int HW = 9;
  localparam int SW = 9;
  localparam int VW = 8;

  // $clog2 returns 0 for a single-entry range; a port still needs one bit.
  function automatic int bits_for(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  localparam int XW = bits_for(DEF_IMG_W);
  localparam int YW = bits_for(DEF_IMG_H);
  localparam int CW = bits_for(DEF_IMG_W * DEF_IMG_H + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_PUBLISH
  } state_t;

  typedef struct packed {
    logic [HW-1:0] h_min;
    logic [HW-1:0] h_max;
    logic [SW-1:0] s_min;
    logic [VW-1:0] v_min;
  } thr_t;

endpackage

// File: rtl/hsv_color_track_cmp.sv
// Combinational colour-window test for one HSV pixel.
// HUE_WRAP_EN: an inverted hue window (h_min > h_max) wraps across 0/360.
module hsv_window_cmp
  import hsv_track_pkg::*;
(
  input  logic [HW-1:0] hsv_h,
  input  logic [SW-1:0] hsv_s,
  input  logic [VW-1:0] hsv_v,
  input  thr_t          thr,
  output logic          match
);

  logic hue_ok;

  // NOTE: every variable written in always_comb gets a default first, so no
  // path through the block leaves it unassigned and no latch is inferred.
  always_comb begin
    hue_ok = 1'b0;
    if (thr.h_min <= thr.h_max) begin
      hue_ok = (hsv_h >= thr.h_min) && (hsv_h <= thr.h_max);
    end else begin
`ifdef HUE_WRAP_EN
      hue_ok = (hsv_h >= thr.h_min) || (hsv_h <= thr.h_max);
`else
      hue_ok = 1'b0;
`endif
    end
  end

  assign match = hue_ok && (hsv_s >= thr.s_min) && (hsv_v >= thr.v_min);

endmodule

// File: rtl/hsv_color_track.sv
// Per-pixel colour mask plus per-frame bounding box / count, published once per frame.
// Optional HUE_WRAP_EN (see hsv_window_cmp) enables wrap-around hue windows.
module hsv_color_track
  import hsv_track_pkg::*;
#(
  parameter int IMG_W   = DEF_IMG_W,
  parameter int IMG_H   = DEF_IMG_H,
  parameter int MIN_PIX = DEF_MIN_PIX
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 din_sop,
  input  logic                                 din_eop,
  input  logic                                 din_vld,
  input  logic [HW-1:0]                        hsv_h,
  input  logic [SW-1:0]                        hsv_s,
  input  logic [VW-1:0]                        hsv_v,
  input  logic [HW-1:0]                        h_min,
  input  logic [HW-1:0]                        h_max,
  input  logic [SW-1:0]                        s_min,
  input  logic [VW-1:0]                        v_min,
  output logic                                 mask,
  output logic                                 dout_sop,
  output logic                                 dout_eop,
  output logic                                 dout_vld,
  output logic [bits_for(IMG_W)-1:0]           box_x0,
  output logic [bits_for(IMG_W)-1:0]           box_x1,
  output logic [bits_for(IMG_H)-1:0]           box_y0,
  output logic [bits_for(IMG_H)-1:0]           box_y1,
  output logic [bits_for(IMG_W*IMG_H+1)-1:0]   pix_cnt,
  output logic                                 found,
  output logic                                 result_vld
);

  localparam int XL = bits_for(IMG_W);
  localparam int YL = bits_for(IMG_H);
  localparam int CL = bits_for(IMG_W * IMG_H + 1);
  localparam logic [XL-1:0] X_LAST = XL'(IMG_W - 1);
  localparam logic [YL-1:0] Y_LAST = YL'(IMG_H - 1);

  state_t state_q, state_d;
  logic   publish;

  thr_t thr_live, thr_q, thr_cur;
  logic start, accept, pix_match, match;

  logic [XL-1:0] x_q, px, bx0_q, bx1_q, bx0, bx1;
  logic [YL-1:0] y_q, py, by0_q, by1_q, by0, by1;
  logic [CL-1:0] cnt_q, cnt;

  assign thr_live = '{h_min: h_min, h_max: h_max, s_min: s_min, v_min: v_min};
  assign start    = din_vld && din_sop;
  assign accept   = din_vld && (din_sop || (state_q == ST_ACTIVE));
  // The sop pixel is judged against the window latched with it, not the old one.
  assign thr_cur  = start ? thr_live : thr_q;
  assign match    = accept && pix_match;

  hsv_window_cmp u_cmp (
    .hsv_h (hsv_h),
    .hsv_s (hsv_s),
    .hsv_v (hsv_v),
    .thr   (thr_cur),
    .match (pix_match)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (start) state_d = din_eop ? ST_PUBLISH : ST_ACTIVE;
      ST_ACTIVE:  if (din_vld && din_eop) state_d = ST_PUBLISH;
      ST_PUBLISH: state_d = start ? (din_eop ? ST_PUBLISH : ST_ACTIVE) : ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    publish = (state_q == ST_PUBLISH);
  end

  // Clear-on-sop merged with the update so the first pixel lands at (0, 0).
  always_comb begin
    px  = start ? '0     : x_q;
    py  = start ? '0     : y_q;
    bx0 = start ? X_LAST : bx0_q;
    bx1 = start ? '0     : bx1_q;
    by0 = start ? Y_LAST : by0_q;
    by1 = start ? '0     : by1_q;
    cnt = start ? '0     : cnt_q;
    if (match) begin
      if (px < bx0) bx0 = px;
      if (px > bx1) bx1 = px;
      if (py < by0) by0 = py;
      if (py > by1) by1 = py;
      if (cnt != '1) cnt = cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      thr_q    <= '0;
      x_q      <= '0;
      y_q      <= '0;
      bx0_q    <= '0;
      bx1_q    <= '0;
      by0_q    <= '0;
      by1_q    <= '0;
      cnt_q    <= '0;
      mask     <= 1'b0;
      dout_sop <= 1'b0;
      dout_eop <= 1'b0;
      dout_vld <= 1'b0;
    end else begin
      mask     <= match;
      dout_vld <= accept;
      dout_sop <= accept && din_sop;
      dout_eop <= accept && din_eop;
      if (start) thr_q <= thr_live;
      if (accept) begin
        x_q   <= (px == X_LAST) ? '0 : px + 1'b1;
        y_q   <= ((px == X_LAST) && (py != Y_LAST)) ? py + 1'b1 : py;
        bx0_q <= bx0;
        bx1_q <= bx1;
        by0_q <= by0;
        by1_q <= by1;
        cnt_q <= cnt;
      end
    end
  end

  // Accumulators are read before any same-cycle sop clears them.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      box_x0     <= '0;
      box_x1     <= '0;
      box_y0     <= '0;
      box_y1     <= '0;
      pix_cnt    <= '0;
      found      <= 1'b0;
      result_vld <= 1'b0;
    end else begin
      result_vld <= publish;
      if (publish) begin
        box_x0  <= (cnt_q == '0) ? '0 : bx0_q;
        box_x1  <= (cnt_q == '0) ? '0 : bx1_q;
        box_y0  <= (cnt_q == '0) ? '0 : by0_q;
        box_y1  <= (cnt_q == '0) ? '0 : by1_q;
        pix_cnt <= cnt_q;
        found   <= (int'(cnt_q) >= MIN_PIX);
      end
    end
  end

endmodule
